mem_porta_arbiter: RTL
======================

Name: mem_porta_arbiter

Overview:
- Shares port A of the 8-lane data SRAM bank (8 x 32-bit lanes, 2-cycle read latency) between the configuration requester and the DMA requester. Replaces the ungated OR of conf/DMA controls in front of the bank.
- Arbitrates per cycle with req/gnt handshakes and registers the SRAM command.
- Tags each read in flight and returns read data plus rvalid to the requester that issued it.

Parameters:
- ADDR_W, 32, SRAM lane word-address width.
- AGE_LIMIT, 8, consecutive cycles a DMA request may be refused before it is forced through.
- SRAM_LAT, 2, SRAM read latency in cycles from the command register output to dout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_conf_req  in  1  conf request, held until granted
- i_conf_we  in  1  1 = write, 0 = read
- i_conf_addr  in  16  byte-style conf address; [15:3] = row, [2] = half select (lanes 0-3 / 4-7)
- i_conf_wdata  in  128  conf write data
- o_conf_gnt  out  1  request accepted this cycle
- o_conf_rvalid  out  1  conf read data valid
- o_conf_rdata  out  128  selected 128-bit half
- i_dma_req  in  1  DMA request, held until granted
- i_dma_we  in  1  1 = write, 0 = read
- i_dma_addr  in  ADDR_W  row address
- i_dma_wdata  in  256  lane data
- i_dma_wstrb  in  8  per-lane write enable
- i_dma_winc  in  8  per-lane row increment (lane uses addr+1)
- o_dma_gnt  out  1  request accepted this cycle
- o_dma_rvalid  out  1  DMA read data valid
- o_dma_rdata  out  256  all 8 lanes
- o_sram_rden  out  8  per-lane read enable
- o_sram_wren  out  8  per-lane write enable
- o_sram_addr  out  8xADDR_W  per-lane address
- o_sram_wdata  out  8x32  per-lane write data
- i_sram_rdata  in  8x32  per-lane read data

Behaviour:
- Reset (sync, i_rst=1 at a clock edge): all outputs 0, age counter 0, tag pipeline cleared. Reads in flight are dropped and no rvalid is produced for them.
- Grant logic (combinational, same cycle as req):
  - Default: conf has priority over DMA.
  - If age_cnt == AGE_LIMIT and i_dma_req=1, DMA is granted and conf waits.
  - At most one gnt per cycle. A gnt is never given without its req.
- Age counter:
  - Increments when i_dma_req=1 and o_dma_gnt=0, saturating at AGE_LIMIT.
  - Clears on o_dma_gnt or when i_dma_req=0.
- Command register: granted command appears on the o_sram_* outputs in cycle T+1 (T = gnt cycle). With no grant, all enables are 0 and addr/wdata hold their values.
- Conf command mapping:
  - row = {zero-ext, i_conf_addr[15:3]}, driven to all 8 lanes.
  - half = i_conf_addr[2]. Write enables lanes 0-3 (half=0) or 4-7 (half=1).
  - wdata 128b is replicated to both halves.
  - A read asserts all 8 rden bits.
- DMA command mapping:
  - Lane i addr = i_dma_addr + i_dma_winc[i] (wraps modulo 2^ADDR_W).
  - wren[i] = i_dma_we & i_dma_wstrb[i]. A read asserts all 8 rden bits.
  - A write with wstrb=0 is granted and is a no-op.
- Read tagging:
  - A shift pipeline of depth 1+SRAM_LAT carries {valid, owner, half}.
  - Read data returns at T+1+SRAM_LAT (3 cycles after gnt with defaults).
  - Conf: o_conf_rdata = half ? lanes 7:4 : lanes 3:0; o_conf_rvalid=1.
  - DMA: o_dma_rdata = all lanes; o_dma_rvalid=1.
  - Between valid returns, rdata holds its last value.
- Throughput: one command per cycle, back-to-back, with reads and writes freely mixed.
  - Read-after-write to the same row issued in consecutive cycles returns the new data (SRAM write-first in program order). No extra hazard logic.
- Simultaneous requests every cycle:
  - Conf wins AGE_LIMIT times, then DMA wins once and the counter clears.
  - The pattern repeats with period AGE_LIMIT+1.

Optional Feature:
- Macro MEM_ARB_RR_EN.
  - Defined: the age counter is removed and strict round-robin is used. A 1-bit last_owner register is updated on every grant; on contention, the requester that is not last_owner wins. Reset value: last_owner = DMA, so conf wins the first contention.
  - Undefined: conf priority with DMA aging, as described above.

Decomposition:
- Package mem_arb_pkg:
  - typedef owner_e {OWN_CONF, OWN_DMA}.
  - struct rd_tag_t {valid, owner, half}.
  - Constants N_LANES=8, LANE_W=32.
- One sub-module, mem_arb_rdtag_pipe: the parameterised tag shift pipeline that produces the per-owner rvalid and half select.

Test Plan:
- Conf write then read: conf write addr 0x0014, wdata 0x...A5A5; 4 cycles later read 0x0014 -> gnt same cycle, wren=8'hF0, row 2; o_conf_rvalid 3 cycles after read gnt with matching data.
- DMA winc: write addr 10, wstrb 8'hFF, winc 8'h0F -> lanes 0-3 addr 11, lanes 4-7 addr 10; read back with the same winc returns wdata and o_dma_rvalid only.
- Contention: both req held for 20 cycles with AGE_LIMIT=8 -> DMA gnt on cycles 8 and 17 only, never two gnts in one cycle.
- Interleaved reads C,D,C,D back-to-back -> rvalids alternate conf/dma on consecutive cycles with correct owner data.
- Reset mid-flight: assert i_rst one cycle after a DMA read gnt -> no o_dma_rvalid afterwards, all outputs 0 next cycle.
- MEM_ARB_RR_EN build: both req held 6 cycles -> grants C,D,C,D,C,D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM port-A arbiter.
package mem_arb_pkg;

  localparam int N_LANES = 8;
  localparam int LANE_W  = 32;

  typedef enum logic {
    OWN_CONF = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   half;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_rdtag_pipe.sv
// Read tag shift pipeline: follows each granted read through the command
// register and the SRAM latency. The tail stage lines up with SRAM dout.
module mem_arb_rdtag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  logic i_owner,
  input  logic i_half,
  output logic o_conf_rvalid,
  output logic o_dma_rvalid,
  output logic o_half
);

  rd_tag_t pipe_q [DEPTH];
  rd_tag_t tail;

  // Shift the tags one stage per cycle; reset drops every read in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0].valid <= i_valid;
      pipe_q[0].owner <= i_owner ? OWN_DMA : OWN_CONF;
      pipe_q[0].half  <= i_half;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  // Decode the tail stage into per-owner strobes.
  always_comb begin
    tail          = pipe_q[DEPTH-1];
    o_conf_rvalid = tail.valid && (tail.owner == OWN_CONF);
    o_dma_rvalid  = tail.valid && (tail.owner == OWN_DMA);
    o_half        = tail.half;
  end

endmodule

// File: rtl/mem_porta_arbiter.sv
// Port-A arbiter for the 8-lane data SRAM bank: conf vs DMA per-cycle
// arbitration, registered SRAM command, and tagged read-data return.
// Build option MEM_ARB_RR_EN: replaces conf-priority-with-DMA-aging by
// strict round-robin on contention.
module mem_porta_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int AGE_LIMIT = 8,
  parameter int SRAM_LAT  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_conf_req,
  input  logic                        i_conf_we,
  input  logic [15:0]                 i_conf_addr,
  input  logic [127:0]                i_conf_wdata,
  output logic                        o_conf_gnt,
  output logic                        o_conf_rvalid,
  output logic [127:0]                o_conf_rdata,
  input  logic                        i_dma_req,
  input  logic                        i_dma_we,
  input  logic [ADDR_W-1:0]           i_dma_addr,
  input  logic [255:0]                i_dma_wdata,
  input  logic [7:0]                  i_dma_wstrb,
  input  logic [7:0]                  i_dma_winc,
  output logic                        o_dma_gnt,
  output logic                        o_dma_rvalid,
  output logic [255:0]                o_dma_rdata,
  output logic [7:0]                  o_sram_rden,
  output logic [7:0]                  o_sram_wren,
  output logic [N_LANES*ADDR_W-1:0]   o_sram_addr,
  output logic [N_LANES*LANE_W-1:0]   o_sram_wdata,
  input  logic [N_LANES*LANE_W-1:0]   i_sram_rdata
);

  localparam int HALF_W = N_LANES * LANE_W / 2;

  logic                      dma_wins;
  logic [ADDR_W-1:0]         conf_row;
  logic [N_LANES-1:0]        cmd_rden;
  logic [N_LANES-1:0]        cmd_wren;
  logic [N_LANES*ADDR_W-1:0] cmd_addr;
  logic [N_LANES*LANE_W-1:0] cmd_wdata;
  logic                      tag_valid;
  logic                      tag_half;
  logic                      rd_half;
  logic [HALF_W-1:0]         conf_sel;
  logic [127:0]              conf_rdata_q;
  logic [255:0]              dma_rdata_q;
  logic                      unused_conf_bits;

  assign unused_conf_bits = ^i_conf_addr[1:0];
  assign conf_row         = ADDR_W'(i_conf_addr[15:3]);

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q;

  // Remember who was served last so contention alternates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_owner_q <= OWN_DMA;
    end else if (o_conf_gnt) begin
      last_owner_q <= OWN_CONF;
    end else if (o_dma_gnt) begin
      last_owner_q <= OWN_DMA;
    end
  end

  assign dma_wins = (last_owner_q == OWN_CONF);
`else
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age_cnt_q;

  // Count consecutive refused DMA cycles, saturating at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      age_cnt_q <= '0;
    end else if (!i_dma_req || o_dma_gnt) begin
      age_cnt_q <= '0;
    end else if (age_cnt_q != AGE_W'(AGE_LIMIT)) begin
      age_cnt_q <= age_cnt_q + AGE_W'(1);
    end
  end

  assign dma_wins = (age_cnt_q == AGE_W'(AGE_LIMIT));
`endif

  // Same-cycle grant: conf by default, DMA when it has won the tie-break.
  always_comb begin
    o_conf_gnt = !i_rst && i_conf_req && !(i_dma_req && dma_wins);
    o_dma_gnt  = !i_rst && i_dma_req && (!i_conf_req || dma_wins);
  end

  // Map the granted request onto per-lane SRAM controls; idle holds addr/wdata.
  always_comb begin
    cmd_rden  = '0;
    cmd_wren  = '0;
    cmd_addr  = o_sram_addr;
    cmd_wdata = o_sram_wdata;
    tag_valid = 1'b0;
    tag_half  = 1'b0;
    if (o_conf_gnt) begin
      for (int l = 0; l < N_LANES; l++) begin
        cmd_addr[l*ADDR_W +: ADDR_W] = conf_row;
      end
      cmd_wdata = {2{i_conf_wdata}};
      tag_half  = i_conf_addr[2];
      if (i_conf_we) begin
        cmd_wren = {{(N_LANES/2){i_conf_addr[2]}}, {(N_LANES/2){~i_conf_addr[2]}}};
      end else begin
        cmd_rden  = '1;
        tag_valid = 1'b1;
      end
    end else if (o_dma_gnt) begin
      for (int l = 0; l < N_LANES; l++) begin
        cmd_addr[l*ADDR_W +: ADDR_W] = i_dma_addr + ADDR_W'(i_dma_winc[l]);
      end
      cmd_wdata = i_dma_wdata;
      if (i_dma_we) begin
        cmd_wren = i_dma_wstrb;
      end else begin
        cmd_rden  = '1;
        tag_valid = 1'b1;
      end
    end
  end

  // SRAM command register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sram_rden  <= '0;
      o_sram_wren  <= '0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
    end else begin
      o_sram_rden  <= cmd_rden;
      o_sram_wren  <= cmd_wren;
      o_sram_addr  <= cmd_addr;
      o_sram_wdata <= cmd_wdata;
    end
  end

  mem_arb_rdtag_pipe #(
    .DEPTH (1 + SRAM_LAT)
  ) u_rdtag (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (tag_valid),
    .i_owner       (o_dma_gnt),
    .i_half        (tag_half),
    .o_conf_rvalid (o_conf_rvalid),
    .o_dma_rvalid  (o_dma_rvalid),
    .o_half        (rd_half)
  );

  // Steer SRAM dout to its owner; hold the last value between returns.
  always_comb begin
    conf_sel     = rd_half ? i_sram_rdata[2*HALF_W-1:HALF_W] : i_sram_rdata[HALF_W-1:0];
    o_conf_rdata = o_conf_rvalid ? conf_sel : conf_rdata_q;
    o_dma_rdata  = o_dma_rvalid ? i_sram_rdata : dma_rdata_q;
  end

  // Capture returned data so it persists after rvalid drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      conf_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      if (o_conf_rvalid) conf_rdata_q <= conf_sel;
      if (o_dma_rvalid)  dma_rdata_q  <= i_sram_rdata;
    end
  end

endmodule
